// File: rtl/meta_pkg.sv
// Shared types and defaults for the N-way tag/metadata array.
// Optional dirty tracking is enabled by defining META_DIRTY_EN.
package meta_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StSweep
    } sweep_state_e;

    localparam int unsigned DefSets = 64;
    localparam int unsigned DefWays = 2;
    localparam int unsigned DefTagW = 7;
    localparam int unsigned DefSetW = $clog2(DefSets);
    localparam int unsigned DefWayW = $clog2(DefWays);

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/meta_lru_set.sv
// True-LRU age logic for one set: victim selection and post-access age vector.
// Ages: 0 = MRU, WAYS-1 = LRU.
module meta_lru_set
    import meta_pkg::*;
#(
    parameter int unsigned WAYS = DefWays,
    parameter int unsigned AW   = idx_w(WAYS)
) (
    input  logic [WAYS-1:0][AW-1:0] age_i,
    input  logic [WAYS-1:0]         valid_i,
    input  logic [AW-1:0]           acc_way_i,
    output logic [AW-1:0]           victim_o,
    output logic [WAYS-1:0][AW-1:0] age_o
);

    logic          found;
    logic [AW-1:0] old_age;

    always_comb begin
        victim_o = '0;
        found    = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!valid_i[w] && !found) begin
                victim_o = AW'(w);
                found    = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_i[w] == AW'(WAYS - 1)) begin
                    victim_o = AW'(w);
                end
            end
        end
    end

    assign old_age = age_i[acc_way_i];

    always_comb begin
        age_o = age_i;
        for (int w = 0; w < WAYS; w++) begin
            if (AW'(w) == acc_way_i) begin
                age_o[w] = '0;
            end else if (age_i[w] < old_age) begin
                age_o[w] = age_i[w] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/meta_tag_array_nway.sv
// N-way set-associative tag/valid/LRU store with registered lookup, LRU fill and
// invalidate-all sweep. Define META_DIRTY_EN to add per-way dirty tracking.
module meta_tag_array_nway
    import meta_pkg::*;
#(
    parameter int unsigned SETS  = DefSets,
    parameter int unsigned WAYS  = DefWays,
    parameter int unsigned TAG_W = DefTagW,
    localparam int unsigned SW   = idx_w(SETS),
    localparam int unsigned AW   = idx_w(WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             lookup_valid_i,
    input  logic [SW-1:0]    lookup_set_i,
    input  logic [TAG_W-1:0] lookup_tag_i,
    output logic             resp_valid_o,
    output logic             hit_o,
    output logic [AW-1:0]    hit_way_o,
    output logic [AW-1:0]    victim_way_o,
    input  logic             fill_valid_i,
    input  logic [SW-1:0]    fill_set_i,
    input  logic [TAG_W-1:0] fill_tag_i,
    output logic [AW-1:0]    fill_way_o,
    output logic             fill_done_o,
    input  logic             inval_start_i,
    output logic             busy_o
`ifdef META_DIRTY_EN
    ,
    input  logic             lookup_wr_i,
    output logic             victim_dirty_o
`endif
);

    logic [SETS-1:0][WAYS-1:0]             valid_q, valid_d;
    logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [SETS-1:0][WAYS-1:0][AW-1:0]     age_q, age_d;
    sweep_state_e                          state_q, state_d;
    logic [SW-1:0]                         cnt_q, cnt_d;

    logic                  resp_valid_q, hit_q, fill_done_q;
    logic [AW-1:0]         hit_way_q, victim_way_q, fill_way_q;

    logic                  busy, lookup_acc, fill_acc, hit_any;
    logic [SW-1:0]         sel_set;
    logic [WAYS-1:0]       hit_vec;
    logic [AW-1:0]         hit_idx, victim, acc_way;
    logic [WAYS-1:0][AW-1:0] next_age;

    assign busy       = (state_q == StSweep);
    assign fill_acc   = fill_valid_i && !busy;
    assign lookup_acc = lookup_valid_i && !fill_valid_i && !busy;
    // Fill wins the shared set port; a concurrent lookup is dropped.
    assign sel_set    = fill_valid_i ? fill_set_i : lookup_set_i;

    always_comb begin
        hit_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[sel_set][w] && (tag_q[sel_set][w] == lookup_tag_i);
        end
        hit_idx = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_idx = AW'(w);
            end
        end
    end

    assign hit_any = |hit_vec;
    assign acc_way = fill_acc ? victim : hit_idx;

    meta_lru_set #(
        .WAYS (WAYS),
        .AW   (AW)
    ) u_lru (
        .age_i     (age_q[sel_set]),
        .valid_i   (valid_q[sel_set]),
        .acc_way_i (acc_way),
        .victim_o  (victim),
        .age_o     (next_age)
    );

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        age_d   = age_q;
        if (busy) begin
            valid_d[cnt_q] = '0;
            for (int w = 0; w < WAYS; w++) begin
                age_d[cnt_q][w] = AW'(w);
            end
        end else if (fill_acc) begin
            valid_d[sel_set][victim] = 1'b1;
            tag_d[sel_set][victim]   = fill_tag_i;
            age_d[sel_set]           = next_age;
        end else if (lookup_acc && hit_any) begin
            age_d[sel_set] = next_age;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (inval_start_i) begin
                    state_d = StSweep;
                    cnt_d   = '0;
                end
            end
            StSweep: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SW'(SETS - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            tag_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= AW'(w);
                end
            end
            state_q      <= StIdle;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            hit_q        <= 1'b0;
            hit_way_q    <= '0;
            victim_way_q <= '0;
            fill_done_q  <= 1'b0;
            fill_way_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            age_q        <= age_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= lookup_acc;
            hit_q        <= lookup_acc && hit_any;
            hit_way_q    <= (lookup_acc && hit_any) ? hit_idx : '0;
            fill_done_q  <= fill_acc;
            if (lookup_acc) begin
                victim_way_q <= victim;
            end
            if (fill_acc) begin
                fill_way_q <= victim;
            end
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign hit_o        = hit_q;
    assign hit_way_o    = hit_way_q;
    assign victim_way_o = victim_way_q;
    assign fill_done_o  = fill_done_q;
    assign fill_way_o   = fill_way_q;
    assign busy_o       = busy;

`ifdef META_DIRTY_EN
    logic [SETS-1:0][WAYS-1:0] dirty_q, dirty_d;
    logic                      victim_dirty_q;

    always_comb begin
        dirty_d = dirty_q;
        if (busy) begin
            dirty_d[cnt_q] = '0;
        end else if (fill_acc) begin
            dirty_d[sel_set][victim] = 1'b0;
        end else if (lookup_acc && hit_any && lookup_wr_i) begin
            dirty_d[sel_set][hit_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dirty_q        <= '0;
            victim_dirty_q <= 1'b0;
        end else begin
            dirty_q <= dirty_d;
            if (lookup_acc) begin
                victim_dirty_q <= dirty_q[sel_set][victim];
            end
        end
    end

    assign victim_dirty_o = victim_dirty_q;
`else
    // Write-through build: no dirty state is kept.
`endif

endmodule

// File: tb/tb_meta_tag_array_nway.sv
// Table-driven, scoreboarded bench for meta_tag_array_nway (SETS=64, WAYS=4).
module tb_meta_tag_array_nway;

    localparam int unsigned SETS  = 64;
    localparam int unsigned WAYS  = 4;
    localparam int unsigned TAG_W = 7;
    localparam int unsigned SW    = 6;
    localparam int unsigned AW    = 2;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             lookup_valid_i, fill_valid_i, inval_start_i;
    logic [SW-1:0]    lookup_set_i, fill_set_i;
    logic [TAG_W-1:0] lookup_tag_i, fill_tag_i;
    logic             resp_valid_o, hit_o, fill_done_o, busy_o;
    logic [AW-1:0]    hit_way_o, victim_way_o, fill_way_o;
`ifdef META_DIRTY_EN
    logic             lookup_wr_i;
    logic             victim_dirty_o;
`endif

    always #5 clk_i = ~clk_i;

    meta_tag_array_nway #(
        .SETS  (SETS),
        .WAYS  (WAYS),
        .TAG_W (TAG_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .lookup_valid_i (lookup_valid_i),
        .lookup_set_i   (lookup_set_i),
        .lookup_tag_i   (lookup_tag_i),
        .resp_valid_o   (resp_valid_o),
        .hit_o          (hit_o),
        .hit_way_o      (hit_way_o),
        .victim_way_o   (victim_way_o),
        .fill_valid_i   (fill_valid_i),
        .fill_set_i     (fill_set_i),
        .fill_tag_i     (fill_tag_i),
        .fill_way_o     (fill_way_o),
        .fill_done_o    (fill_done_o),
        .inval_start_i  (inval_start_i),
        .busy_o         (busy_o)
`ifdef META_DIRTY_EN
        ,
        .lookup_wr_i    (lookup_wr_i),
        .victim_dirty_o (victim_dirty_o)
`endif
    );

    // op: 0 idle, 1 lookup, 2 fill, 3 fill+lookup (lookup dropped), 4 lookup while busy
    typedef struct {
        int op; int inv; int set; int ltag; int ftag; int wr;
        int hit; int hway; int vic; int fway; int vd;
    } vec_t;

    typedef struct {
        bit resp; bit hit; int hway; int vic; bit fdone; int fway; int vd; int id;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   vec_id   = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(input int op, input int inv, input int set, input int ltag,
                                input int ftag, input int wr, input int hit, input int hway,
                                input int vic, input int fway, input int vd);
        vec_t v;
        v.op = op; v.inv = inv; v.set = set; v.ltag = ltag; v.ftag = ftag; v.wr = wr;
        v.hit = hit; v.hway = hway; v.vic = vic; v.fway = fway; v.vd = vd;
        return v;
    endfunction

    task automatic idle_inputs();
        lookup_valid_i = 1'b0;
        fill_valid_i   = 1'b0;
        inval_start_i  = 1'b0;
        lookup_set_i   = '0;
        lookup_tag_i   = '0;
        fill_set_i     = '0;
        fill_tag_i     = '0;
`ifdef META_DIRTY_EN
        lookup_wr_i    = 1'b0;
`endif
    endtask

    // Call right after a negedge: drives one cycle of stimulus and queues its outcome.
    task automatic apply(input vec_t v);
        exp_t e;
        lookup_valid_i = (v.op == 1) || (v.op == 3) || (v.op == 4);
        fill_valid_i   = (v.op == 2) || (v.op == 3);
        inval_start_i  = (v.inv != 0);
        lookup_set_i   = SW'(v.set);
        fill_set_i     = SW'(v.set);
        lookup_tag_i   = TAG_W'(v.ltag);
        fill_tag_i     = TAG_W'(v.ftag);
`ifdef META_DIRTY_EN
        lookup_wr_i    = (v.wr != 0);
`endif
        e.resp  = (v.op == 1);
        e.hit   = (v.hit != 0);
        e.hway  = v.hway;
        e.vic   = v.vic;
        e.fdone = (v.op == 2) || (v.op == 3);
        e.fway  = v.fway;
        e.vd    = v.vd;
        e.id    = vec_id;
        vec_id++;
        sb.push_back(e);
    endtask

    always @(posedge clk_i) begin : monitor
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("v%0d resp_valid", e.id), int'(resp_valid_o), int'(e.resp));
            if (e.resp) begin
                chk($sformatf("v%0d hit", e.id), int'(hit_o), int'(e.hit));
                chk($sformatf("v%0d hit_way", e.id), int'(hit_way_o), e.hway);
                chk($sformatf("v%0d victim_way", e.id), int'(victim_way_o), e.vic);
`ifdef META_DIRTY_EN
                if (e.vd >= 0) begin
                    chk($sformatf("v%0d victim_dirty", e.id), int'(victim_dirty_o), e.vd);
                end
`endif
            end
            chk($sformatf("v%0d fill_done", e.id), int'(fill_done_o), int'(e.fdone));
            if (e.fdone) begin
                chk($sformatf("v%0d fill_way", e.id), int'(fill_way_o), e.fway);
            end
        end
    end

    initial begin
        vec_t main_tbl[$];
        vec_t post_tbl[$];
        vec_t dirty_tbl[$];
        int   nbusy;

        // Hand-derived LRU walk through set 3 (WAYS=4), plus fill/lookup collision on set 7.
        main_tbl.push_back(mk(1, 0, 5, 'h12, 0,     0, 0, 0, 0, 0, -1));
        main_tbl.push_back(mk(2, 0, 3, 0,    'h10,  0, 0, 0, 0, 0, -1));
        main_tbl.push_back(mk(2, 0, 3, 0,    'h11,  0, 0, 0, 0, 1, -1));
        main_tbl.push_back(mk(2, 0, 3, 0,    'h12,  0, 0, 0, 0, 2, -1));
        main_tbl.push_back(mk(2, 0, 3, 0,    'h13,  0, 0, 0, 0, 3, -1));
        main_tbl.push_back(mk(2, 0, 3, 0,    'h14,  0, 0, 0, 0, 0, -1));
        main_tbl.push_back(mk(1, 0, 3, 'h10, 0,     0, 0, 0, 1, 0, -1));
        main_tbl.push_back(mk(1, 0, 3, 'h14, 0,     0, 1, 0, 1, 0, -1));
        main_tbl.push_back(mk(1, 0, 3, 'h11, 0,     0, 1, 1, 1, 0, -1));
        main_tbl.push_back(mk(1, 0, 3, 'h14, 0,     0, 1, 0, 2, 0, -1));
        main_tbl.push_back(mk(1, 0, 3, 'h13, 0,     0, 1, 3, 2, 0, -1));
        main_tbl.push_back(mk(1, 0, 3, 'h12, 0,     0, 1, 2, 2, 0, -1));
        main_tbl.push_back(mk(1, 0, 3, 'h55, 0,     0, 0, 0, 1, 0, -1));
        main_tbl.push_back(mk(3, 0, 7, 'h22, 'h22,  0, 0, 0, 0, 0, -1));
        main_tbl.push_back(mk(1, 0, 7, 'h22, 0,     0, 1, 0, 1, 0, -1));
        main_tbl.push_back(mk(2, 0, 3, 0,    'h66,  0, 0, 0, 0, 1, -1));
        main_tbl.push_back(mk(1, 0, 3, 'h11, 0,     0, 0, 0, 0, 0, -1));
        main_tbl.push_back(mk(0, 0, 0, 0,    0,     0, 0, 0, 0, 0, -1));

        post_tbl.push_back(mk(1, 0, 3, 'h14, 0,     0, 0, 0, 0, 0, -1));
        post_tbl.push_back(mk(1, 0, 3, 'h12, 0,     0, 0, 0, 0, 0, -1));
        post_tbl.push_back(mk(1, 0, 3, 'h66, 0,     0, 0, 0, 0, 0, -1));
        post_tbl.push_back(mk(1, 0, 7, 'h22, 0,     0, 0, 0, 0, 0, -1));
        post_tbl.push_back(mk(2, 0, 3, 0,    'h70,  0, 0, 0, 0, 0, -1));
        post_tbl.push_back(mk(1, 0, 3, 'h70, 0,     0, 1, 0, 1, 0, -1));
        post_tbl.push_back(mk(0, 0, 0, 0,    0,     0, 0, 0, 0, 0, -1));

        // Dirty walk on set 11: write-hit way 0, age it to LRU, then refill and re-age.
        dirty_tbl.push_back(mk(2, 0, 11, 0,    'h40, 0, 0, 0, 0, 0, -1));
        dirty_tbl.push_back(mk(2, 0, 11, 0,    'h41, 0, 0, 0, 0, 1, -1));
        dirty_tbl.push_back(mk(2, 0, 11, 0,    'h42, 0, 0, 0, 0, 2, -1));
        dirty_tbl.push_back(mk(2, 0, 11, 0,    'h43, 0, 0, 0, 0, 3, -1));
        dirty_tbl.push_back(mk(1, 0, 11, 'h40, 0,    1, 1, 0, 0, 0, 0));
        dirty_tbl.push_back(mk(1, 0, 11, 'h41, 0,    0, 1, 1, 1, 0, 0));
        dirty_tbl.push_back(mk(1, 0, 11, 'h42, 0,    0, 1, 2, 2, 0, 0));
        dirty_tbl.push_back(mk(1, 0, 11, 'h43, 0,    0, 1, 3, 3, 0, 0));
        dirty_tbl.push_back(mk(1, 0, 11, 'h77, 0,    0, 0, 0, 0, 0, 1));
        dirty_tbl.push_back(mk(2, 0, 11, 0,    'h78, 0, 0, 0, 0, 0, -1));
        dirty_tbl.push_back(mk(1, 0, 11, 'h41, 0,    0, 1, 1, 1, 0, 0));
        dirty_tbl.push_back(mk(1, 0, 11, 'h42, 0,    0, 1, 2, 2, 0, 0));
        dirty_tbl.push_back(mk(1, 0, 11, 'h43, 0,    0, 1, 3, 3, 0, 0));
        dirty_tbl.push_back(mk(1, 0, 11, 'h77, 0,    0, 0, 0, 0, 0, 0));
        dirty_tbl.push_back(mk(0, 0, 0,  0,    0,    0, 0, 0, 0, 0, -1));

        idle_inputs();
        #1;
        chk("reset resp_valid", int'(resp_valid_o), 0);
        chk("reset hit", int'(hit_o), 0);
        chk("reset hit_way", int'(hit_way_o), 0);
        chk("reset victim_way", int'(victim_way_o), 0);
        chk("reset fill_way", int'(fill_way_o), 0);
        chk("reset fill_done", int'(fill_done_o), 0);
        chk("reset busy", int'(busy_o), 0);
        #20;
        @(negedge clk_i);
        rst_ni = 1'b1;

        foreach (main_tbl[i]) begin
            @(negedge clk_i);
            apply(main_tbl[i]);
        end

        // Sweep: second inval_start while busy must be ignored.
        @(negedge clk_i);
        apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, -1));
        nbusy = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk_i);
            if (busy_o) nbusy++;
            if (i == 0) chk("busy after inval_start", int'(busy_o), 1);
            apply(mk((i < 64) ? 4 : 0, (i == 5) ? 1 : 0, i, 'h12, 0, 0, 0, 0, 0, 0, -1));
        end
        chk("sweep busy cycles", nbusy, 64);

        foreach (post_tbl[i]) begin
            @(negedge clk_i);
            apply(post_tbl[i]);
        end

`ifdef META_DIRTY_EN
        foreach (dirty_tbl[i]) begin
            @(negedge clk_i);
            apply(dirty_tbl[i]);
        end
`endif

        // Reset in the middle of a sweep.
        @(negedge clk_i);
        idle_inputs();
        inval_start_i = 1'b1;
        @(negedge clk_i);
        inval_start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("mid-sweep busy", int'(busy_o), 1);
        rst_ni = 1'b0;
        #1;
        chk("reset during sweep busy", int'(busy_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Reset right after a fill: the written tag must not survive.
        @(negedge clk_i);
        fill_valid_i = 1'b1;
        fill_set_i   = SW'(9);
        fill_tag_i   = TAG_W'('h33);
        @(negedge clk_i);
        idle_inputs();
        chk("pre-reset fill_done", int'(fill_done_o), 1);
        rst_ni = 1'b0;
        #1;
        chk("reset after fill fill_done", int'(fill_done_o), 0);
        chk("reset after fill busy", int'(busy_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        apply(mk(1, 0, 9, 'h33, 0, 0, 0, 0, 0, 0, -1));
        @(negedge clk_i);
        apply(mk(1, 0, 3, 'h70, 0, 0, 0, 0, 0, 0, -1));
        @(negedge clk_i);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));

        repeat (3) @(negedge clk_i);
        chk("scoreboard drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/meta_tag_array_nway.md
# meta_tag_array_nway

Parametrised N-way set-associative tag/metadata array for the cache processor: stores tag, valid bit and true-LRU age per way, performs registered tag lookups, fills into the LRU (or first invalid) victim way, and supports a sequential invalidate-all sweep. It replaces the fixed 64-set, 2-way, single-LRU-bit tag store and sits between the cache controller FSM and the data array, supplying hit/way and victim selection.

## Interface
- SETS, 64, number of sets; power of 2, ≥2
- WAYS, 2, associativity; power of 2, 2..8
- TAG_W, 7, tag width in bits
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- lookup_valid  in  1  lookup request
- lookup_set  in  log2(SETS)  lookup index
- lookup_tag  in  TAG_W  lookup tag
- resp_valid  out  1  lookup result valid (one cycle after accepted lookup)
- hit  out  1  tag matched a valid way
- hit_way  out  log2(WAYS)  matching way; 0 on miss
- victim_way  out  log2(WAYS)  way a fill to this set would replace
- fill_valid  in  1  install fill_tag in victim way of fill_set
- fill_set  in  log2(SETS)  fill index
- fill_tag  in  TAG_W  fill tag
- fill_way  out  log2(WAYS)  way written by the fill (registered, valid with fill_done)
- fill_done  out  1  one-cycle pulse after fill write
- inval_start  in  1  begin invalidate-all sweep
- busy  out  1  sweep in progress

## Operation
- Per set, per way: valid, tag[TAG_W], age[log2(WAYS)]. Ages in a set always form a permutation of 0..WAYS-1; 0 = MRU, WAYS-1 = LRU.
- Lookup: accepted when lookup_valid & ~fill_valid & ~busy. Compare lookup_tag against all valid ways of lookup_set; at most one may match (fill never creates duplicates if controller fills only after a miss).
- Victim: lowest-index invalid way; if all valid, way with age WAYS-1. Reported on every response, hit or miss.
- Access update: on hit, or on fill, accessed way age←0; every way with age < accessed way's old age increments; others unchanged.
- Fill: valid←1, tag←fill_tag in victim of fill_set (victim computed from current state, same cycle), then access update. Fill has priority over lookup; a lookup presented with fill_valid is dropped (no resp_valid).
- Sweep FSM: IDLE → SWEEP on inval_start (ignored if busy). SWEEP clears valid and resets ages to way index for set counter 0..SETS-1, one set per cycle; after set SETS-1 → IDLE. busy=1 throughout SWEEP; lookups and fills ignored.
- Reset: all valid=0, ages[w]=w for every set, FSM IDLE, counter 0.

## Timing
- Reset values: resp_valid=0, hit=0, hit_way=0, victim_way=0, fill_way=0, fill_done=0, busy=0.
- Lookup latency 1: request at cycle N → resp_valid/hit/hit_way/victim_way at N+1; LRU update for a hit committed at the N→N+1 edge (compare on input-side state).
- Back-to-back lookups every cycle supported; a lookup at N+1 to the same set sees the LRU update from N.
- Fill at cycle N: arrays updated at edge end of N; fill_done/fill_way at N+1. Lookup at N+1 to the same set hits the new tag.
- Sweep: inval_start at N → busy=1 from N+1 for exactly SETS cycles.
- rst asserted mid-sweep or mid-fill: immediate return to reset state; no partial write survives.

## Configuration
- META_DIRTY_EN defined: adds per-way dirty bit, inputs lookup_wr (1), outputs victim_dirty (1). Hit with lookup_wr sets dirty; fill clears it; sweep and reset clear it; victim_dirty registered with victim_way.
- Undefined: no dirty storage or ports; write-through behaviour only.

## Structure
- Shared package meta_pkg: sweep state enum (IDLE, SWEEP), localparams for index/way widths derived via $clog2, default SETS/WAYS/TAG_W.
- One sub-module: meta_lru_set — per-set age vector, computes victim and next-age vector given accessed way and valid mask.

## Test plan
- After reset, lookup set 5 tag 0x12 → resp_valid=1, hit=0, victim_way=0 next cycle.
- WAYS=4: fill set 3 with tags 0x10,0x11,0x12,0x13 → fill_way 0,1,2,3; fifth fill 0x14 → fill_way=0 (LRU); lookup 0x10 → miss.
- WAYS=4 set 3 full, hit way 0 then way 1 → victim_way=2; ages remain a permutation.
- fill_valid and lookup_valid same cycle same set → fill_done pulse, no resp_valid; lookup next cycle hits fill tag.
- SETS=64: inval_start → busy high exactly 64 cycles, lookups during sweep produce no response; afterwards every prior tag misses.
- META_DIRTY_EN: hit with lookup_wr on way 1 of full 2-way set, then miss with way 1 as victim → victim_dirty=1; after fill, victim_dirty=0.
